// File: rtl/hdmi_period_ctrl.sv
// HDMI period scheduler: delays the pixel stream by an 11-cycle lead and sequences
// control / preamble / guard-band / video / data-island periods for the TMDS encoders.
module hdmi_period_ctrl #(
  parameter int unsigned PIXEL_W  = 24,
  parameter int unsigned MAX_PKTS = 18,
  parameter int unsigned MIN_CTRL = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               de_in,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic [PIXEL_W-1:0] pix_in,
  input  logic [15:0]        blank_left,
  input  logic               island_req,
  input  logic [4:0]         island_pkts,
  output logic               island_ack,
  output logic [2:0]         mode,
  output logic [3:0]         ctl,
  output logic               vid_hs,
  output logic               vid_vs,
  output logic [PIXEL_W-1:0] vid_pix,
  output logic [4:0]         island_pkt,
  output logic [4:0]         island_word,
  output logic               err
);

  localparam int unsigned Lead = 11;
  localparam int unsigned CntW = $clog2(MIN_CTRL + 2);
  localparam logic [CntW-1:0] MinCtrl = CntW'(MIN_CTRL);
  localparam logic [4:0] MaxPkts = 5'(MAX_PKTS);

  typedef enum logic [2:0] {
    StCtrl, StVpre, StVgb, StVideo, StIpre, StIgbLead, StIsland, StIgbTrail
  } state_e;

  logic [Lead-1:0]    de_dly_q, hs_dly_q, vs_dly_q;
  logic [PIXEL_W-1:0] pix_dly_q [Lead];

  state_e          state_q, state_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [4:0]      word_q, word_d, pkt_q, pkt_d, n_q, n_d;
  logic [CntW-1:0] ctrl_cnt_q, ctrl_cnt_d;
  logic            ack_d, err_d;
  logic [2:0]      mode_d;
  logic [3:0]      ctl_d;

  logic        de_rise, de_late, pkts_legal, island_ok, in_island;
  logic [15:0] island_need;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_dly_q <= '0;
      hs_dly_q <= '0;
      vs_dly_q <= '0;
      for (int i = 0; i < Lead; i++) pix_dly_q[i] <= '0;
    end else begin
      de_dly_q     <= {de_dly_q[Lead-2:0], de_in};
      hs_dly_q     <= {hs_dly_q[Lead-2:0], hs_in};
      vs_dly_q     <= {vs_dly_q[Lead-2:0], vs_in};
      pix_dly_q[0] <= pix_in;
      for (int i = 1; i < Lead; i++) pix_dly_q[i] <= pix_dly_q[i-1];
    end
  end

  // State runs one cycle ahead of the registered outputs, so the FSM looks one tap
  // short of the line end to keep mode aligned with vid_*.
  assign de_rise     = de_in & ~de_dly_q[0];
  assign de_late     = de_dly_q[Lead-2];
  assign pkts_legal  = (island_pkts != 5'd0) && (island_pkts <= MaxPkts);
  assign island_need = 16'd24 + {6'd0, island_pkts, 5'd0};
  assign island_ok   = (ctrl_cnt_q >= MinCtrl) && !de_in && !de_late && island_req &&
                       pkts_legal && (blank_left >= island_need);
  assign in_island   = (state_q == StIpre) || (state_q == StIgbLead) ||
                       (state_q == StIsland) || (state_q == StIgbTrail);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    pkt_d   = pkt_q;
    n_d     = n_q;
    ack_d   = 1'b0;
    err_d   = err;
    unique case (state_q)
      StCtrl: begin
        if (de_rise) begin
          state_d = StVpre;
          cnt_d   = 9'd7;
        end else if (island_ok) begin
          state_d = StIpre;
          cnt_d   = 9'd7;
          ack_d   = 1'b1;
          n_d     = island_pkts;
        end
      end
      StVpre: begin
        if (cnt_q == 9'd0) begin
          state_d = StVgb;
          cnt_d   = 9'd1;
        end else cnt_d = cnt_q - 9'd1;
      end
      StVgb: begin
        if (cnt_q == 9'd0) state_d = StVideo;
        else cnt_d = cnt_q - 9'd1;
      end
      StVideo: if (!de_late) state_d = StCtrl;
      StIpre: begin
        if (cnt_q == 9'd0) begin
          state_d = StIgbLead;
          cnt_d   = 9'd1;
        end else cnt_d = cnt_q - 9'd1;
      end
      StIgbLead: begin
        if (cnt_q == 9'd0) begin
          state_d = StIsland;
          word_d  = 5'd0;
          pkt_d   = 5'd0;
        end else cnt_d = cnt_q - 9'd1;
      end
      StIsland: begin
        if (word_q == 5'd31 && pkt_q == n_q - 5'd1) begin
          state_d = StIgbTrail;
          cnt_d   = 9'd1;
        end else begin
          word_d = word_q + 5'd1;
          if (word_q == 5'd31) pkt_d = pkt_q + 5'd1;
        end
      end
      StIgbTrail: begin
        if (cnt_q == 9'd0) state_d = StCtrl;
        else cnt_d = cnt_q - 9'd1;
      end
      default: state_d = StCtrl;
    endcase
    // Upstream opened video early: drop the island and start the video lead now.
    if (in_island && de_in) begin
      state_d = StVpre;
      cnt_d   = 9'd7;
      err_d   = 1'b1;
    end
    ctrl_cnt_d = '0;
    if (state_q == StCtrl && state_d == StCtrl) begin
      ctrl_cnt_d = (ctrl_cnt_q >= MinCtrl) ? ctrl_cnt_q : ctrl_cnt_q + 1'b1;
    end
  end

  always_comb begin
    mode_d = 3'd0;
    ctl_d  = 4'b0000;
    unique case (state_q)
      StVpre:                mode_d = 3'd0;
      StVgb:                 mode_d = 3'd2;
      StVideo:               mode_d = 3'd1;
      StIpre:                mode_d = 3'd0;
      StIgbLead, StIgbTrail: mode_d = 3'd4;
      StIsland:              mode_d = 3'd3;
      default:               mode_d = 3'd0;
    endcase
    if (state_q == StVpre) ctl_d = 4'b0001;
    if (state_q == StIpre) ctl_d = 4'b0101;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StCtrl;
      cnt_q       <= '0;
      word_q      <= '0;
      pkt_q       <= '0;
      n_q         <= '0;
      ctrl_cnt_q  <= '0;
      island_ack  <= 1'b0;
      err         <= 1'b0;
      mode        <= 3'd0;
      ctl         <= 4'b0000;
      island_word <= '0;
      island_pkt  <= '0;
      vid_hs      <= 1'b0;
      vid_vs      <= 1'b0;
      vid_pix     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      pkt_q       <= pkt_d;
      n_q         <= n_d;
      ctrl_cnt_q  <= ctrl_cnt_d;
      island_ack  <= ack_d;
      err         <= err_d;
      mode        <= mode_d;
      ctl         <= ctl_d;
      island_word <= (state_q == StIsland) ? word_q : 5'd0;
      island_pkt  <= (state_q == StIsland) ? pkt_q : 5'd0;
      vid_hs      <= hs_dly_q[Lead-1];
      vid_vs      <= vs_dly_q[Lead-1];
      vid_pix     <= pix_dly_q[Lead-1];
    end
  end

endmodule

// File: tb/tb_hdmi_period_ctrl.sv
// Directed bench for hdmi_period_ctrl: video lead, islands, refusals and abort,
// with expected outputs queued at stimulus time and popped as the DUT produces them.
module tb_hdmi_period_ctrl;
  localparam int unsigned PW = 24;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [PW-1:0] pix_in = '0;
  logic [15:0]   blank_left = '0;
  logic          island_req = 1'b0;
  logic [4:0]    island_pkts = '0;
  logic          island_ack;
  logic [2:0]    mode;
  logic [3:0]    ctl;
  logic          vid_hs, vid_vs;
  logic [PW-1:0] vid_pix;
  logic [4:0]    island_pkt, island_word;
  logic          err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] mode;
    logic [3:0] ctl;
    logic [4:0] pkt;
    logic [4:0] word;
  } sched_t;

  sched_t        sched_q[$];
  logic [PW+1:0] vid_q[$];

  hdmi_period_ctrl #(.PIXEL_W(PW), .MAX_PKTS(18), .MIN_CTRL(4)) dut (
    .clk(clk), .reset_n(reset_n), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .pix_in(pix_in), .blank_left(blank_left), .island_req(island_req),
    .island_pkts(island_pkts), .island_ack(island_ack), .mode(mode), .ctl(ctl),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_pix(vid_pix), .island_pkt(island_pkt),
    .island_word(island_word), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_island(input int n);
    for (int k = 0; k < 8; k++) sched_q.push_back('{3'd0, 4'b0101, 5'd0, 5'd0});
    for (int k = 0; k < 2; k++) sched_q.push_back('{3'd4, 4'b0000, 5'd0, 5'd0});
    for (int j = 0; j < 32 * n; j++) sched_q.push_back('{3'd3, 4'b0000, 5'(j / 32), 5'(j % 32)});
    for (int k = 0; k < 2; k++) sched_q.push_back('{3'd4, 4'b0000, 5'd0, 5'd0});
    sched_q.push_back('{3'd0, 4'b0000, 5'd0, 5'd0});
  endtask

  task automatic drain(input string tag);
    sched_t e;
    while (sched_q.size() > 0) begin
      tick();
      e = sched_q.pop_front();
      chk($sformatf("%s.mode", tag), 32'(mode), 32'(e.mode));
      if (e.mode != 3'd3) chk($sformatf("%s.ctl", tag), 32'(ctl), 32'(e.ctl));
      chk($sformatf("%s.word", tag), 32'(island_word), 32'(e.word));
      chk($sformatf("%s.pkt", tag), 32'(island_pkt), 32'(e.pkt));
      chk($sformatf("%s.ack_once", tag), 32'(island_ack), 32'd0);
    end
  endtask

  task automatic wait_ack(input string tag, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (island_ack) got = 1'b1;
    end
    chk(tag, 32'(got), 32'd1);
    island_req = 1'b0;
  endtask

  task automatic count_acks(input string tag, input int cycles);
    int acks = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (island_ack) acks++;
    end
    chk(tag, 32'(acks), 32'd0);
  endtask

  initial begin
    // Reset held with busy inputs.
    for (int i = 0; i < 6; i++) begin
      de_in  = 1'($urandom);
      hs_in  = 1'($urandom);
      pix_in = PW'($urandom);
      tick();
    end
    chk("rst.mode", 32'(mode), 32'd0);
    chk("rst.ctl", 32'(ctl), 32'd0);
    chk("rst.vid_pix", 32'(vid_pix), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.ack", 32'(island_ack), 32'd0);
    de_in   = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("idle.mode", 32'(mode), 32'd0);
    end

    // Video line: de_in high for 100 samples starting at relative edge 0.
    for (int k = 0; k < 126; k++) begin
      de_in  = (k < 100);
      hs_in  = 1'($urandom);
      vs_in  = 1'($urandom);
      pix_in = PW'($urandom);
      if (de_in) vid_q.push_back({hs_in, vs_in, pix_in});
      tick();
      if (k >= 1 && k <= 8) begin
        chk("vpre.mode", 32'(mode), 32'd0);
        chk("vpre.ctl", 32'(ctl), 32'b0001);
      end else if (k == 9 || k == 10) begin
        chk("vgb.mode", 32'(mode), 32'd2);
      end else if (k >= 11 && k <= 110) begin
        chk("video.mode", 32'(mode), 32'd1);
        chk("video.data", 32'({vid_hs, vid_vs, vid_pix}), 32'(vid_q.pop_front()));
      end else begin
        chk("ctrl.mode", 32'(mode), 32'd0);
        chk("ctrl.ctl", 32'(ctl), 32'd0);
      end
    end

    // Island of two packets with ample blanking.
    island_req  = 1'b1;
    island_pkts = 5'd2;
    blank_left  = 16'd200;
    wait_ack("isl2.ack", 40);
    push_island(2);
    drain("isl2");

    // Blanking one short of the requirement, then exactly enough.
    island_req = 1'b1;
    blank_left = 16'd87;
    count_acks("refuse87", 20);
    blank_left = 16'd88;
    wait_ack("accept88.ack", 40);
    push_island(2);
    drain("isl88");

    // Illegal packet counts.
    blank_left  = 16'd1000;
    island_req  = 1'b1;
    island_pkts = 5'd0;
    count_acks("pkts0", 30);
    island_pkts = 5'd19;
    count_acks("pkts19", 30);
    island_req = 1'b0;
    chk("pre_abort.err", 32'(err), 32'd0);

    // Abort: de_in rises in the middle of a four-packet island.
    island_pkts = 5'd4;
    island_req  = 1'b1;
    wait_ack("isl4.ack", 40);
    for (int i = 0; i < 50; i++) tick();
    chk("mid_island.mode", 32'(mode), 32'd3);
    de_in = 1'b1;
    tick();
    chk("abort.err", 32'(err), 32'd1);
    tick();
    chk("abort.ctl", 32'(ctl), 32'b0001);
    chk("abort.mode", 32'(mode), 32'd0);
    for (int i = 0; i < 20; i++) tick();
    de_in = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("abort.err_sticky", 32'(err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
